// File: rtl/fir_tap_feeder_pkg.sv
// Shared definitions for the FIR tap feeder and the FIR logic it drives.
// - FIR_FEED_* : 2-bit state encodings of the feeder FSM.
// - feed_state_e : typed FSM state built on those encodings.
// - tap_lsb() : tap-slice convention, tap k lives at [k*I_WIDTH +: I_WIDTH].
package fir_tap_feeder_pkg;

  localparam logic [1:0] FIR_FEED_FILL = 2'd0;
  localparam logic [1:0] FIR_FEED_RUN  = 2'd1;
  localparam logic [1:0] FIR_FEED_HOLD = 2'd2;

  typedef enum logic [1:0] {
    StFill = FIR_FEED_FILL,
    StRun  = FIR_FEED_RUN,
    StHold = FIR_FEED_HOLD
  } feed_state_e;

  function automatic int tap_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// ORDER-deep tap delay line of I_WIDTH-bit samples.
// - clk_i, rst_ni : clock, asynchronous active-low reset
// - clr_i         : synchronous clear of all taps (wins over shift_i)
// - shift_i       : tap 0 <= data_i, tap k <= tap k-1
// - data_i        : incoming sample
// - taps_o        : packed taps, tap 0 newest
module fir_delay_line
  import fir_tap_feeder_pkg::*;
#(
  parameter int unsigned I_WIDTH = 16,
  parameter int unsigned ORDER   = 17
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       shift_i,
  input  logic [I_WIDTH-1:0]         data_i,
  output logic [I_WIDTH*ORDER-1:0]   taps_o
);

  logic [I_WIDTH*ORDER-1:0] taps_q, taps_d;

  always_comb begin
    taps_d = taps_q;
    if (clr_i) begin
      taps_d = '0;
    end else if (shift_i) begin
      taps_d[I_WIDTH-1:0] = data_i;
      for (int k = 1; k < int'(ORDER); k++) begin
        taps_d[tap_lsb(k, int'(I_WIDTH)) +: I_WIDTH] =
            taps_q[tap_lsb(k - 1, int'(I_WIDTH)) +: I_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir_tap_feeder.sv
// Feeds the CSD FIR: shifts accepted samples into a tap delay line, decimates,
// and holds the taps for SETTLE cycles per evaluation (multicycle adder tree).
// - i_clk, i_rst_n : clock, asynchronous active-low reset
// - i_flush        : synchronous clear of taps, counters and FSM (top priority)
// - i_valid/o_ready/i_data : sample handshake (o_ready registered, 0 in HOLD)
// - o_taps         : packed taps to FIR i_data, tap 0 newest
// - o_en           : taps form an evaluation set and are frozen
// - o_res_valid    : one-cycle pulse, FIR registered output valid
module fir_tap_feeder
  import fir_tap_feeder_pkg::*;
#(
  parameter int unsigned I_WIDTH    = 16,
  parameter int unsigned ORDER      = 17,
  parameter int unsigned DECIMATION = 4,
  parameter int unsigned SETTLE     = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [I_WIDTH-1:0]       i_data,
  output logic [I_WIDTH*ORDER-1:0] o_taps,
  output logic                     o_en,
  output logic                     o_res_valid
);

  localparam int unsigned FillW = $clog2(ORDER + 1);
  localparam int unsigned DecW  = $clog2(DECIMATION) + 1;
  localparam int unsigned HoldW = $clog2(SETTLE) + 1;

  localparam logic [FillW-1:0] FillLast = FillW'(ORDER - 1);
  localparam logic [FillW-1:0] FillSat  = FillW'(ORDER);
  localparam logic [DecW-1:0]  DecLast  = DecW'(DECIMATION - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(SETTLE - 1);

  feed_state_e      state_q;
  logic [FillW-1:0] fill_cnt_q;
  logic [DecW-1:0]  dec_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             ready_q;
  logic             en_q;
  logic             res_valid_q;
  logic             accept;

  // ready_q is already 0 throughout HOLD, so taps cannot move while o_en is high.
  assign accept = i_valid && ready_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StFill;
      fill_cnt_q  <= '0;
      dec_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (i_flush) begin
      // Aborts any evaluation in flight: no o_res_valid will follow.
      state_q     <= StFill;
      fill_cnt_q  <= '0;
      dec_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      ready_q     <= 1'b1;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (fill_cnt_q == FillLast) begin
              fill_cnt_q <= FillSat;
              dec_cnt_q  <= '0;
              hold_cnt_q <= '0;
              state_q    <= StHold;
              en_q       <= 1'b1;
              ready_q    <= 1'b0;
            end else begin
              fill_cnt_q <= fill_cnt_q + FillW'(1);
            end
          end
        end
        StRun: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (dec_cnt_q == DecLast) begin
              dec_cnt_q  <= '0;
              hold_cnt_q <= '0;
              state_q    <= StHold;
              en_q       <= 1'b1;
              ready_q    <= 1'b0;
            end else begin
              dec_cnt_q <= dec_cnt_q + DecW'(1);
            end
          end
        end
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            hold_cnt_q  <= '0;
            state_q     <= StRun;
            en_q        <= 1'b0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        default: begin
          state_q <= StFill;
        end
      endcase
    end
  end

  fir_delay_line #(
    .I_WIDTH(I_WIDTH),
    .ORDER  (ORDER)
  ) u_delay_line (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (i_flush),
    .shift_i(accept),
    .data_i (i_data),
    .taps_o (o_taps)
  );

  assign o_ready     = ready_q;
  assign o_en        = en_q;
  assign o_res_valid = res_valid_q;

endmodule

// File: tb/tb_fir_tap_feeder.sv
module tb_fir_tap_feeder;

  localparam int W   = 16;
  localparam int ORD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: ORDER=3, DECIMATION=2, SETTLE=2. Instance B: ORDER=3, DECIMATION=1, SETTLE=1.
  logic          a_rst_n = 1'b1, a_flush = 1'b0, a_valid = 1'b0;
  logic [W-1:0]  a_data  = '0;
  logic [3*W-1:0] a_taps;
  logic          a_en, a_ready, a_res;
  logic          b_rst_n = 1'b1, b_flush = 1'b0, b_valid = 1'b0;
  logic [W-1:0]  b_data  = '0;
  logic [3*W-1:0] b_taps;
  logic          b_en, b_ready, b_res;

  fir_tap_feeder #(.I_WIDTH(W), .ORDER(ORD), .DECIMATION(2), .SETTLE(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_flush(a_flush), .i_valid(a_valid),
    .o_ready(a_ready), .i_data(a_data), .o_taps(a_taps), .o_en(a_en),
    .o_res_valid(a_res)
  );

  fir_tap_feeder #(.I_WIDTH(W), .ORDER(ORD), .DECIMATION(1), .SETTLE(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_flush(b_flush), .i_valid(b_valid),
    .o_ready(b_ready), .i_data(b_data), .o_taps(b_taps), .o_en(b_en),
    .o_res_valid(b_res)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: history of accepted samples since clear, evaluation decided by
  // sample count arithmetic, busy window measured in remaining hold cycles.
  logic [W-1:0] m_taps[2][ORD];
  int           m_cnt[2];
  int           m_hold[2];
  bit           m_ready[2];
  bit           m_res[2];
  int           p_dec[2] = '{2, 1};
  int           p_set[2] = '{2, 1};

  function automatic bit evaluates(input int n, input int dec);
    return (n == ORD) || (n > ORD && ((n - ORD) % dec) == 0);
  endfunction

  function automatic logic [3*W+2:0] exp_of(input int i);
    return {m_taps[i][2], m_taps[i][1], m_taps[i][0], m_hold[i] > 0, m_ready[i], m_res[i]};
  endfunction

  task automatic model_reset(input int i);
    for (int k = 0; k < ORD; k++) m_taps[i][k] = '0;
    m_cnt[i] = 0; m_hold[i] = 0; m_ready[i] = 1'b0; m_res[i] = 1'b0;
  endtask

  task automatic model_edge(input int i, input bit v, input logic [W-1:0] d, input bit f);
    bit acc;
    if (f) begin
      for (int k = 0; k < ORD; k++) m_taps[i][k] = '0;
      m_cnt[i] = 0; m_hold[i] = 0; m_ready[i] = 1'b1; m_res[i] = 1'b0;
    end else if (m_hold[i] > 0) begin
      m_res[i]  = (m_hold[i] == 1);
      m_hold[i] = m_hold[i] - 1;
      if (m_hold[i] == 0) m_ready[i] = 1'b1;
    end else begin
      m_res[i]   = 1'b0;
      acc        = v && m_ready[i];
      m_ready[i] = 1'b1;
      if (acc) begin
        for (int k = ORD - 1; k > 0; k--) m_taps[i][k] = m_taps[i][k-1];
        m_taps[i][0] = d;
        m_cnt[i]     = m_cnt[i] + 1;
        if (evaluates(m_cnt[i], p_dec[i])) begin
          m_hold[i]  = p_set[i];
          m_ready[i] = 1'b0;
        end
      end
    end
  endtask

  // Inputs change on the falling edge; model follows each rising edge; outputs sampled at next fall.
  task automatic tick();
    @(posedge clk);
    if (!a_rst_n) model_reset(0); else model_edge(0, a_valid, a_data, a_flush);
    if (!b_rst_n) model_reset(1); else model_edge(1, b_valid, b_data, b_flush);
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    model_reset(0); model_reset(1);
    #1;
    checks++;
    if ({a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
      errors++;
      $display("FAIL reset_values: got %h want %h", {a_taps, a_en, a_ready, a_res}, exp_of(0));
    end
    @(negedge clk);
    tick();
    a_rst_n = 1'b1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", a_ready);
    end
    tick();
    checks++;
    if ({a_taps, a_en, a_ready, a_res} !== exp_of(0) || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: got %h want %h", {a_taps, a_en, a_ready, a_res}, exp_of(0));
    end
  endtask

  task automatic test_fill_eval();
    logic [W-1:0] s[3] = '{16'd1, 16'd2, 16'd3};
    a_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      a_data = s[n];
      tick();
      checks++;
      if ({a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL fill_%0d: got %h want %h", n, {a_taps, a_en, a_ready, a_res}, exp_of(0));
      end
    end
    a_valid = 1'b0;
    checks++;
    if (a_taps !== 48'h0001_0002_0003 || a_en !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL first_eval_taps: got %h en %b rdy %b want 000100020003 en 1 rdy 0",
               a_taps, a_en, a_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL first_hold_%0d: got %h want %h", c, {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
      if (c == 1) begin
        checks++;
        if (a_res !== 1'b1 || a_en !== 1'b0) begin
          errors++;
          $display("FAIL res_pulse: got res %b en %b want res 1 en 0", a_res, a_en);
        end
      end
    end
  endtask

  task automatic test_decimate();
    a_valid = 1'b1; a_data = 16'd4;
    tick();
    a_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (a_en !== 1'b0 || {a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL no_eval_after_4: got %h want %h", {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
      tick();
    end
    a_valid = 1'b1; a_data = 16'd5;
    tick();
    a_valid = 1'b0;
    checks++;
    if (a_taps !== 48'h0003_0004_0005 || a_en !== 1'b1) begin
      errors++;
      $display("FAIL eval_after_5: got %h en %b want 000300040005 en 1", a_taps, a_en);
    end
  endtask

  task automatic test_hold_valid();
    bit pre;
    int accepts = 0;
    a_valid = 1'b1; a_data = 16'd6;
    for (int c = 0; c < 6; c++) begin
      pre = m_ready[0] && a_valid;
      if (pre) begin
        checks++;
        if (a_res !== 1'b1) begin
          errors++;
          $display("FAIL accept_in_res_cycle: got res %b want 1", a_res);
        end
      end
      tick();
      if (pre) begin
        accepts++;
        a_valid = 1'b0;
      end
      checks++;
      if ({a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL hold_valid_%0d: got %h want %h", c, {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
    end
    checks++;
    if (a_taps !== 48'h0004_0005_0006 || accepts != 1) begin
      errors++;
      $display("FAIL single_shift: got %h (%0d accepts) want 000400050006 (1 accept)",
               a_taps, accepts);
    end
  endtask

  task automatic test_flush_hold();
    logic [W-1:0] s[3] = '{16'd7, 16'd8, 16'd9};
    a_valid = 1'b1; a_data = 16'h0070;
    tick();
    checks++;
    if (a_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush_hold: got en %b want 1", a_en);
    end
    a_flush = 1'b1; a_data = 16'h0071;
    tick();
    a_flush = 1'b0; a_valid = 1'b0;
    checks++;
    if (a_taps !== '0 || a_en !== 1'b0 || a_res !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: got taps %h en %b res %b want 0 0 0", a_taps, a_en, a_res);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (a_res !== 1'b0 || {a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL flush_no_res_%0d: got %h want %h", c, {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
    end
    for (int n = 0; n < 3; n++) begin
      a_valid = 1'b1; a_data = s[n];
      tick();
      a_valid = 1'b0;
      checks++;
      if (a_en !== (n == 2) || {a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL refill_%0d: got %h want %h", n, {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
      if (n < 2) tick();
    end
    checks++;
    if (a_taps !== 48'h0007_0008_0009) begin
      errors++;
      $display("FAIL refill_taps: got %h want 000700080009", a_taps);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_midfill();
    logic [W-1:0] s[5] = '{16'h11, 16'h12, 16'h21, 16'h22, 16'h23};
    a_valid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      a_data = s[n];
      tick();
    end
    a_valid = 1'b0;
    a_rst_n = 1'b0;
    model_reset(0);
    #1;
    checks++;
    if ({a_taps, a_en, a_ready, a_res} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {a_taps, a_en, a_ready, a_res});
    end
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
    a_valid = 1'b1;
    for (int n = 2; n < 5; n++) begin
      a_data = s[n];
      tick();
      checks++;
      if (a_en !== (n == 4) || {a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL fresh_fill_%0d: got %h want %h", n, {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
    end
    a_valid = 1'b0;
    checks++;
    if (a_taps !== 48'h0021_0022_0023) begin
      errors++;
      $display("FAIL fresh_taps: got %h want 002100220023", a_taps);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r = 16'd1;
    logic [W-1:0] last0 = '0;
    bit seen_en = 1'b0, seen_res = 1'b0, prev_en = 1'b0, pre;
    b_rst_n = 1'b1;
    b_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      b_data = r;
      pre = m_ready[1];
      tick();
      if (pre) r = r + 16'd1;
      checks++;
      if ({b_taps, b_en, b_ready, b_res} !== exp_of(1)) begin
        errors++;
        $display("FAIL b2b_model_%0d: got %h want %h", c, {b_taps, b_en, b_ready, b_res},
                 exp_of(1));
      end
      if (seen_en) begin
        checks++;
        if (b_en === prev_en || b_res !== prev_en) begin
          errors++;
          $display("FAIL b2b_toggle_%0d: got en %b res %b want en %b res %b", c, b_en, b_res,
                   !prev_en, prev_en);
        end
      end
      if (b_res === 1'b1) begin
        checks++;
        if ((seen_res && b_taps[W-1:0] !== last0 + 16'd1) ||
            b_taps[2*W-1:W] !== b_taps[W-1:0] - 16'd1 ||
            b_taps[3*W-1:2*W] !== b_taps[W-1:0] - 16'd2) begin
          errors++;
          $display("FAIL b2b_ramp_%0d: got %h after tap0 %h", c, b_taps, last0);
        end
        last0 = b_taps[W-1:0];
        seen_res = 1'b1;
      end
      if (b_en === 1'b1) seen_en = 1'b1;
      prev_en = b_en;
    end
    b_valid = 1'b0;
    checks++;
    if (!seen_res) begin
      errors++;
      $display("FAIL b2b_no_result: got none want res pulses");
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      a_valid = ($urandom_range(0, 9) < 7);
      a_data  = W'($urandom);
      a_flush = ($urandom_range(0, 39) == 0);
      b_valid = ($urandom_range(0, 9) < 8);
      b_data  = W'($urandom);
      b_flush = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if ({a_taps, a_en, a_ready, a_res} !== exp_of(0)) begin
        errors++;
        $display("FAIL rand_a_%0d: got %h want %h", c, {a_taps, a_en, a_ready, a_res},
                 exp_of(0));
      end
      checks++;
      if ({b_taps, b_en, b_ready, b_res} !== exp_of(1)) begin
        errors++;
        $display("FAIL rand_b_%0d: got %h want %h", c, {b_taps, b_en, b_ready, b_res},
                 exp_of(1));
      end
    end
    a_valid = 1'b0; a_flush = 1'b0; b_valid = 1'b0; b_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_eval();
    test_decimate();
    test_hold_valid();
    test_flush_hold();
    test_reset_midfill();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
